// File: rtl/spi_pkg.sv
// ----------------------------------------------------------------------------
// spi_pkg
// Shared types for the SPI master transaction sequencer.
//   seq_state_t : sequencer FSM states
//   SS_W        : slave-select width
//   SPI_W       : default SPI word width
//   spi_req_t   : one queued request (payload + slave select) at SPI_W
// ----------------------------------------------------------------------------
package spi_pkg;

    localparam int SS_W  = 2;
    localparam int SPI_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT,
        CAPTURE,
        RESP
    } seq_state_t;

    // Request at the default word width. The sequencer builds an identical
    // layout at its own `width`, so a non-default width still works.
    typedef struct packed {
        logic [SPI_W-1:0] data;
        logic [SS_W-1:0]  ss;
    } spi_req_t;

endpackage

// File: rtl/spi_req_fifo.sv
// ----------------------------------------------------------------------------
// spi_req_fifo
// Synchronous request FIFO. Push is ignored when full, pop is ignored when
// empty; a simultaneous push and pop (not full, not empty) leaves the
// occupancy unchanged. Pointers wrap modulo depth (a power of two).
// Ports:
//   clk, rst       clock, asynchronous active-high reset (empties the FIFO)
//   push_i         write push_data_i when not full
//   push_data_i    request to store
//   pop_i          drop the head when not empty
//   pop_data_o     current head (valid while !empty_o)
//   full_o         occupancy == depth
//   empty_o        occupancy == 0
//   count_o        occupancy, $clog2(depth)+1 bits
// ----------------------------------------------------------------------------
module spi_req_fifo
    import spi_pkg::*;
#(
    parameter int  depth  = 4,
    parameter type item_t = spi_req_t
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  item_t                    push_data_i,
    input  logic                     pop_i,
    output item_t                    pop_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(depth):0]   count_o
);

    localparam int PTR_W = $clog2(depth);
    localparam int CNT_W = PTR_W + 1;

    item_t              mem_q [depth];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic               do_push;
    logic               do_pop;

    assign full_o     = (count_q == CNT_W'(depth));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign pop_data_o = mem_q[rd_ptr_q];
    assign do_push    = push_i && !full_o;
    assign do_pop     = pop_i && !empty_o;

    // NOTE: storage has no reset; the occupancy count alone decides which
    // entries are meaningful, and an unreset array maps onto plain RAM/flops.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // NOTE: sequential state is updated with <= so every block samples the
    // pre-edge values regardless of evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/spi_master_sequencer.sv
// ----------------------------------------------------------------------------
// spi_master_sequencer
// Buffers SPI transfer requests and launches them one at a time into the SPI
// master, waits a fixed transfer window, then returns the received word over
// a valid/ready response handshake.
// Parameters: width (word width), depth (FIFO entries, power of two >= 2),
//             xfer_cycles (cycles from up_data until m_data is valid, >= 1).
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   req_valid/req_ready         request handshake; req_ready = FIFO not full
//   req_data, req_ss            payload and target slave
//   up_data                     one-cycle load strobe to the master
//   data, top_ss                word and slave select to the master
//   m_data                      word received by the master
//   rsp_valid/rsp_ready         response handshake
//   rsp_data, rsp_ss            captured m_data and its slave
//   xfer_count                  completed handshakes (SPI_SEQ_STATS_EN only)
// Optional build macro: SPI_SEQ_STATS_EN adds the xfer_count port/counter.
// ----------------------------------------------------------------------------
module spi_master_sequencer
    import spi_pkg::*;
#(
    parameter int width       = 8,
    parameter int depth       = 4,
    parameter int xfer_cycles = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [width-1:0]  req_data,
    input  logic [SS_W-1:0]   req_ss,
    output logic              up_data,
    output logic [width-1:0]  data,
    output logic [SS_W-1:0]   top_ss,
    input  logic [width-1:0]  m_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [width-1:0]  rsp_data,
    output logic [SS_W-1:0]   rsp_ss
`ifdef SPI_SEQ_STATS_EN
    ,
    output logic [15:0]       xfer_count
`endif
);

    typedef struct packed {
        logic [width-1:0] data;
        logic [SS_W-1:0]  ss;
    } req_t;

    localparam int CNT_W = (xfer_cycles > 1) ? $clog2(xfer_cycles) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(xfer_cycles - 1);

    seq_state_t               state_q;
    logic [CNT_W-1:0]         cnt_q;
    logic                     up_data_q;
    logic [width-1:0]         data_q;
    logic [SS_W-1:0]          top_ss_q;
    logic                     rsp_valid_q;
    logic [width-1:0]         rsp_data_q;
    logic [SS_W-1:0]          rsp_ss_q;

    req_t                     head;
    req_t                     push_item;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic                     fifo_pop;
    logic [$clog2(depth):0]   fifo_count;

    assign push_item = '{data: req_data, ss: req_ss};
    assign fifo_pop  = (state_q == IDLE) && !fifo_empty;
    assign req_ready = !fifo_full;

    spi_req_fifo #(
        .depth  (depth),
        .item_t (req_t)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (req_valid),
        .push_data_i (push_item),
        .pop_i       (fifo_pop),
        .pop_data_o  (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    // All outputs are registered, so each state's action is committed on the
    // edge that enters it: up_data is loaded leaving LOAD (high during START)
    // and the response is captured leaving the last WAIT cycle (valid during
    // CAPTURE). CAPTURE therefore already honours rsp_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            up_data_q   <= 1'b0;
            data_q      <= '0;
            top_ss_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_ss_q    <= '0;
        end else begin
            up_data_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        data_q   <= head.data;
                        top_ss_q <= head.ss;
                        state_q  <= LOAD;
                    end
                end
                LOAD: begin
                    up_data_q <= 1'b1;
                    state_q   <= START;
                end
                START: begin
                    cnt_q   <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (cnt_q == CNT_LAST) begin
                        rsp_data_q  <= m_data;
                        rsp_ss_q    <= top_ss_q;
                        rsp_valid_q <= 1'b1;
                        state_q     <= CAPTURE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                CAPTURE, RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end else begin
                        state_q <= RESP;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign up_data   = up_data_q;
    assign data      = data_q;
    assign top_ss    = top_ss_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_ss    = rsp_ss_q;

`ifdef SPI_SEQ_STATS_EN
    logic [15:0] xfer_count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xfer_count_q <= '0;
        end else if (rsp_valid_q && rsp_ready) begin
            xfer_count_q <= xfer_count_q + 16'd1;
        end
    end

    assign xfer_count = xfer_count_q;
`endif

endmodule

// File: tb/tb_spi_master_sequencer.sv
// ----------------------------------------------------------------------------
// tb_spi_master_sequencer
// Self-checking bench for spi_master_sequencer. A transaction-level model
// (request queue, "cycles since pop" counter) predicts every output each
// cycle; directed scenarios plus a randomized phase drive the DUT.
// ----------------------------------------------------------------------------
module tb_spi_master_sequencer;

    localparam int W     = 8;
    localparam int DEPTH = 4;
    localparam int XC    = 20;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [W-1:0] req_data = '0;
    logic [1:0]   req_ss = '0;
    logic         up_data;
    logic [W-1:0] data;
    logic [1:0]   top_ss;
    logic [W-1:0] m_data = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [W-1:0] rsp_data;
    logic [1:0]   rsp_ss;
`ifdef SPI_SEQ_STATS_EN
    logic [15:0]  xfer_count;
`endif

    always #5 clk = ~clk;

    spi_master_sequencer #(
        .width       (W),
        .depth       (DEPTH),
        .xfer_cycles (XC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_ss    (req_ss),
        .up_data   (up_data),
        .data      (data),
        .top_ss    (top_ss),
        .m_data    (m_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_ss    (rsp_ss)
`ifdef SPI_SEQ_STATS_EN
        ,
        .xfer_count(xfer_count)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Requests are {ss, data}. m_k counts cycles since the pop edge:
    // 1 = load, 2 = strobe, 3..XC+2 = transfer window, >= XC+3 = response.
    logic [9:0]  mq[$];
    logic [9:0]  acc_q[$];
    logic [9:0]  launch_q[$];
    bit          m_busy;
    int          m_k;
    logic [9:0]  m_cur;
    logic [9:0]  m_rsp;
    logic [15:0] m_count;

    task automatic model_reset();
        mq.delete();
        acc_q.delete();
        launch_q.delete();
        m_busy  = 0;
        m_k     = 0;
        m_cur   = '0;
        m_rsp   = '0;
        m_count = '0;
    endtask

    task automatic model_edge();
        bit can_push;
        if (rst) begin
            model_reset();
            return;
        end
        can_push = mq.size() < DEPTH;
        if (m_busy) begin
            if (m_k == XC + 2) m_rsp = {m_cur[9:8], m_data};
            if (m_k >= XC + 3 && rsp_ready) begin
                m_busy = 0;
                m_count++;
            end else begin
                m_k++;
            end
        end else if (mq.size() > 0) begin
            m_cur  = mq.pop_front();
            m_busy = 1;
            m_k    = 1;
        end
        if (req_valid && can_push) begin
            mq.push_back({req_ss, req_data});
            acc_q.push_back({req_ss, req_data});
        end
    endtask

    task automatic compare_all();
        check("req_ready", req_ready, mq.size() < DEPTH);
        check("occupancy", dut.fifo_count, mq.size());
        check("up_data", up_data, m_busy && m_k == 2);
        check("data", data, m_cur[7:0]);
        check("top_ss", top_ss, m_cur[9:8]);
        check("rsp_valid", rsp_valid, m_busy && m_k >= XC + 3);
        check("rsp_data", rsp_data, m_rsp[7:0]);
        check("rsp_ss", rsp_ss, m_rsp[9:8]);
`ifdef SPI_SEQ_STATS_EN
        check("xfer_count", xfer_count, m_count);
`endif
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
        if (up_data) launch_q.push_back({top_ss, data});
    endtask

    // Run until the model has nothing left, then check launch order.
    task automatic drain(input int budget);
        int n = 0;
        while ((m_busy || mq.size() > 0) && n < budget) begin
            cycle();
            n++;
        end
        check("drain_idle", {rsp_valid, dut.fifo_count}, 0);
        check("launch_count", launch_q.size(), acc_q.size());
        for (int i = 0; i < launch_q.size() && i < acc_q.size(); i++)
            check("launch_order", launch_q[i], acc_q[i]);
        launch_q.delete();
        acc_q.delete();
    endtask

    initial begin
        int seen;
        bit pushed;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        compare_all();
        check("reset_ready", req_ready, 1);
        rst = 1'b0;

        // Single request: strobe in cycle 3, response in cycle XC+4.
        m_data = 8'h3C; rsp_ready = 1'b1;
        req_valid = 1'b1; req_data = 8'hA5; req_ss = 2'b00;
        cycle();
        req_valid = 1'b0;
        for (int i = 2; i <= XC + 6; i++) begin
            cycle();
            if (i == 3) begin
                check("s1_up_pulse", up_data, 1);
                check("s1_data", data, 8'hA5);
                check("s1_top_ss", top_ss, 0);
            end
            if (i == XC + 4) begin
                check("s1_rsp_valid", rsp_valid, 1);
                check("s1_rsp_data", rsp_data, 8'h3C);
                check("s1_rsp_ss", rsp_ss, 0);
            end
        end
        drain(10);

        // Fill with the consumer stalled, then push past full.
        rsp_ready = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            req_valid = 1'b1; req_data = 8'(i); req_ss = 2'(i);
            m_data = 8'($urandom);
            cycle();
        end
        req_valid = 1'b0;
        check("s2_full", req_ready, 0);
        repeat (XC + 8) cycle();
        check("s2_rsp_hold", rsp_valid, 1);
        repeat (5) cycle();
        check("s2_rsp_hold2", rsp_valid, 1);
        rsp_ready = 1'b1;
        drain(8 * (XC + 8));

        // Reset during the transfer window with another request queued.
        req_valid = 1'b1; req_data = 8'h77; req_ss = 2'd3;
        cycle();
        req_data = 8'h78;
        cycle();
        req_valid = 1'b0;
        repeat (6) cycle();
        rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        check("rst_ready", req_ready, 1);
        check("rst_up", up_data, 0);
        repeat (2) cycle();
        rst = 1'b0;
        seen = 0;
        repeat (XC + 10) begin
            cycle();
            if (rsp_valid || up_data) seen++;
        end
        check("rst_no_rsp", seen, 0);

        // Push in the same cycle IDLE pops, with two entries queued.
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req_valid = 1'b1; req_data = 8'(8'h40 + i); req_ss = 2'(i);
            cycle();
        end
        req_valid = 1'b0;
        repeat (XC + 6) cycle();
        rsp_ready = 1'b1;
        pushed = 0;
        for (int n = 0; n < XC + 10 && !pushed; n++) begin
            if (!m_busy && mq.size() == 2) begin
                req_valid = 1'b1; req_data = 8'h55; req_ss = 2'd1;
                cycle();
                req_valid = 1'b0;
                check("s4_occ_hold", dut.fifo_count, 2);
                pushed = 1;
            end else begin
                cycle();
            end
        end
        check("s4_pushed", pushed, 1);
        drain(6 * (XC + 8));

        // Randomized traffic.
        for (int n = 0; n < 1500; n++) begin
            req_valid = 1'($urandom_range(0, 1));
            req_data  = 8'($urandom);
            req_ss    = 2'($urandom);
            m_data    = 8'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        drain(8 * (XC + 8));

`ifdef SPI_SEQ_STATS_EN
        // Counter wrap from 0xFFFF.
        force dut.xfer_count_q = 16'hFFFF;
        #1;
        release dut.xfer_count_q;
        m_count = 16'hFFFF;
        req_valid = 1'b1; req_data = 8'h9A; req_ss = 2'd2;
        cycle();
        req_valid = 1'b0;
        drain(2 * (XC + 8));
        check("stats_wrap", xfer_count, 16'h0000);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
